// File: rtl/cci_mpf_fiu_rsp_pkg.sv
// Shared types for the FIU response model: CCI field widths and request FIFO entries.
package cci_mpf_fiu_rsp_pkg;

   typedef logic [41:0]  t_line_addr;
   typedef logic [15:0]  t_mdata;
   typedef logic [511:0] t_line;

   localparam int LINE_ADDR_W = $bits(t_line_addr);

   typedef struct packed {
      t_line_addr addr;
      t_mdata     mdata;
   } t_rd_entry;

   typedef struct packed {
      logic       fence;
      t_line_addr addr;
      t_mdata     mdata;
      t_line      data;
   } t_wr_entry;

endpackage

// File: rtl/cci_mpf_fiu_rsp_model_if.sv
// AFU<->FIU request/response bundle; the AFU side is master, the responder is slave.
interface cci_mpf_fiu_rsp_model_if;
   import cci_mpf_fiu_rsp_pkg::*;

   logic       c0_req_valid;
   t_line_addr c0_req_addr;
   t_mdata     c0_req_mdata;
   logic       c0_almfull;
   logic       c1_req_valid;
   logic       c1_req_fence;
   t_line_addr c1_req_addr;
   t_line      c1_req_data;
   t_mdata     c1_req_mdata;
   logic       c1_almfull;
   logic       c0_rsp_valid;
   t_line      c0_rsp_data;
   t_mdata     c0_rsp_mdata;
   logic       c1_rsp_valid;
   logic       c1_rsp_fence;
   t_mdata     c1_rsp_mdata;
   logic       overflow_err;

   modport master (
      output c0_req_valid, c0_req_addr, c0_req_mdata,
      output c1_req_valid, c1_req_fence, c1_req_addr, c1_req_data, c1_req_mdata,
      input  c0_almfull, c1_almfull,
      input  c0_rsp_valid, c0_rsp_data, c0_rsp_mdata,
      input  c1_rsp_valid, c1_rsp_fence, c1_rsp_mdata, overflow_err
   );

   modport slave (
      input  c0_req_valid, c0_req_addr, c0_req_mdata,
      input  c1_req_valid, c1_req_fence, c1_req_addr, c1_req_data, c1_req_mdata,
      output c0_almfull, c1_almfull,
      output c0_rsp_valid, c0_rsp_data, c0_rsp_mdata,
      output c1_rsp_valid, c1_rsp_fence, c1_rsp_mdata, overflow_err
   );

endinterface

// File: rtl/cci_mpf_fiu_rsp_fifo.sv
// Synchronous request FIFO with occupancy count, registered almost-full and sticky overflow.
module cci_mpf_fiu_rsp_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 4,
   parameter int SLACK     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     pop_data,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   count,
   output logic                 almfull,
   output logic                 overflow
);
   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(DEPTH);
   localparam logic [DEPTH_LOG:0] THRESH   = (DEPTH_LOG+1)'(DEPTH - SLACK);

   logic [WIDTH-1:0]     store [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
   logic                 full, do_push, do_pop;
   logic [DEPTH_LOG:0]   count_next;

   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   assign do_push    = push && !full;
   assign do_pop     = pop && !empty;
   assign count_next = count + (DEPTH_LOG+1)'(do_push) - (DEPTH_LOG+1)'(do_pop);
   assign pop_data   = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

   // Almost-full tracks the post-update occupancy so it is visible the cycle after the push.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         almfull  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count_next;
         almfull  <= (count_next >= THRESH);
         overflow <= overflow | (push & full);
      end
   end

endmodule

// File: rtl/cci_mpf_fiu_rsp_model.sv
// FIU-side responder: queues c0 reads and c1 writes/fences against a local line memory.
module cci_mpf_fiu_rsp_model
   import cci_mpf_fiu_rsp_pkg::*;
#(
   parameter int MEM_LINES_LOG  = 10,
   parameter int FIFO_DEPTH_LOG = 4,
   parameter int ALMFULL_SLACK  = 4,
   parameter int RD_LATENCY     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   cci_mpf_fiu_rsp_model_if.slave cci
);
   localparam int MEM_LINES = 1 << MEM_LINES_LOG;

   t_rd_entry                 rd_push_entry, rd_head;
   t_wr_entry                 wr_push_entry, wr_head;
   logic                      rd_empty, wr_empty, rd_pop, wr_pop, rd_ovf, wr_ovf;
   logic                      rd_hold;
   logic [FIFO_DEPTH_LOG:0]   rd_count, wr_count;
   logic [MEM_LINES_LOG-1:0]  rd_idx, wr_idx;
   t_line                     mem [MEM_LINES];
   logic [RD_LATENCY:1]       rd_vld_p;
   t_mdata                    rd_mdata_p [1:RD_LATENCY];
   t_line                     rd_data_p  [1:RD_LATENCY];
   logic                      wr_vld_p1, wr_fence_p1;
   t_mdata                    wr_mdata_p1;
   logic                      unused;

   // Read-queue hold hook, tied off; simulation can force it to back up the read FIFO.
   assign rd_hold = 1'b0;

   assign rd_push_entry = '{addr: cci.c0_req_addr, mdata: cci.c0_req_mdata};
   assign wr_push_entry = '{fence: cci.c1_req_fence, addr: cci.c1_req_addr,
                            mdata: cci.c1_req_mdata, data: cci.c1_req_data};

   cci_mpf_fiu_rsp_fifo #(.WIDTH($bits(t_rd_entry)), .DEPTH_LOG(FIFO_DEPTH_LOG), .SLACK(ALMFULL_SLACK))
   u_rd_fifo (.clk(clk), .reset(reset), .push(cci.c0_req_valid), .push_data(rd_push_entry),
              .pop(rd_pop), .pop_data(rd_head), .empty(rd_empty), .count(rd_count),
              .almfull(cci.c0_almfull), .overflow(rd_ovf));

   cci_mpf_fiu_rsp_fifo #(.WIDTH($bits(t_wr_entry)), .DEPTH_LOG(FIFO_DEPTH_LOG), .SLACK(ALMFULL_SLACK))
   u_wr_fifo (.clk(clk), .reset(reset), .push(cci.c1_req_valid), .push_data(wr_push_entry),
              .pop(wr_pop), .pop_data(wr_head), .empty(wr_empty), .count(wr_count),
              .almfull(cci.c1_almfull), .overflow(wr_ovf));

   assign rd_pop = !reset && !rd_empty && !rd_hold;
   assign wr_pop = !reset && !wr_empty;
   assign rd_idx = rd_head.addr[MEM_LINES_LOG-1:0];
   assign wr_idx = wr_head.addr[MEM_LINES_LOG-1:0];

   always_ff @(posedge clk) begin
      if (wr_pop && !wr_head.fence) mem[wr_idx] <= wr_head.data;
   end

   // Stage 1 samples memory on the pop edge, so a same-cycle write to the index is not seen.
   always_ff @(posedge clk) begin
      rd_data_p[1]  <= mem[rd_idx];
      rd_mdata_p[1] <= rd_head.mdata;
      for (int i = 2; i <= RD_LATENCY; i++) begin
         rd_data_p[i]  <= rd_data_p[i-1];
         rd_mdata_p[i] <= rd_mdata_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) rd_vld_p <= '0;
      else       rd_vld_p <= {rd_vld_p[RD_LATENCY-1:1], rd_pop};
   end

   // Write and fence acks leave one cycle after the pop; FIFO order keeps fences behind writes.
   always_ff @(posedge clk) begin
      if (reset) wr_vld_p1 <= 1'b0;
      else       wr_vld_p1 <= wr_pop;
   end

   always_ff @(posedge clk) begin
      wr_fence_p1 <= wr_head.fence;
      wr_mdata_p1 <= wr_head.mdata;
   end

   assign cci.c0_rsp_valid = rd_vld_p[RD_LATENCY];
   assign cci.c0_rsp_data  = rd_data_p[RD_LATENCY];
   assign cci.c0_rsp_mdata = rd_mdata_p[RD_LATENCY];
   assign cci.c1_rsp_valid = wr_vld_p1;
   assign cci.c1_rsp_fence = wr_fence_p1;
   assign cci.c1_rsp_mdata = wr_mdata_p1;
   assign cci.overflow_err = rd_ovf | wr_ovf;

   assign unused = ^{rd_head.addr[LINE_ADDR_W-1:MEM_LINES_LOG],
                     wr_head.addr[LINE_ADDR_W-1:MEM_LINES_LOG], rd_count, wr_count};

endmodule

// File: tb/tb_cci_mpf_fiu_rsp_model.sv
// Bench for cci_mpf_fiu_rsp_model: random and directed traffic against a queue/array reference.
module tb_cci_mpf_fiu_rsp_model;
   localparam int LAT  = 8;
   localparam int MLOG = 10;

   typedef struct { int unsigned cyc; logic [511:0] data; logic [15:0] mdata; } c0_rec_t;
   typedef struct { int unsigned cyc; logic fence; logic [15:0] mdata; } c1_rec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   c0_rec_t     c0_obs[$], c0_exp[$];
   c1_rec_t     c1_obs[$], c1_exp[$];
   logic [511:0] ref_mem [int];

   cci_mpf_fiu_rsp_model_if bus();

   cci_mpf_fiu_rsp_model #(.MEM_LINES_LOG(MLOG), .FIFO_DEPTH_LOG(4), .ALMFULL_SLACK(4), .RD_LATENCY(LAT))
   dut (.clk(clk), .reset(reset), .cci(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      c0_rec_t r0;
      c1_rec_t r1;
      if (bus.c0_rsp_valid === 1'b1) begin
         r0.cyc = cyc; r0.data = bus.c0_rsp_data; r0.mdata = bus.c0_rsp_mdata;
         c0_obs.push_back(r0);
      end
      if (bus.c1_rsp_valid === 1'b1) begin
         r1.cyc = cyc; r1.fence = bus.c1_rsp_fence; r1.mdata = bus.c1_rsp_mdata;
         c1_obs.push_back(r1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Reference: a write is acked 2 cycles after its push; a read returns the line as of its
   // push, LAT+1 cycles later (queues are idle when requests are issued back to back).
   task automatic model_wr(input int unsigned t, input logic [41:0] a, input logic [511:0] d,
                           input logic [15:0] m, input logic f);
      c1_rec_t r;
      r.cyc = t + 2; r.fence = f; r.mdata = m;
      c1_exp.push_back(r);
      if (!f) ref_mem[int'(a[MLOG-1:0])] = d;
   endtask

   task automatic model_rd(input int unsigned t, input logic [41:0] a, input logic [15:0] m);
      c0_rec_t r;
      int idx = int'(a[MLOG-1:0]);
      r.cyc = t + LAT + 1; r.mdata = m;
      r.data = ref_mem.exists(idx) ? ref_mem[idx] : 'x;
      c0_exp.push_back(r);
   endtask

   task automatic flush();
      c0_obs.delete(); c0_exp.delete(); c1_obs.delete(); c1_exp.delete();
   endtask

   task automatic rd_req(input logic [41:0] a, input logic [15:0] m);
      model_rd(cyc, a, m);
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = a; bus.c0_req_mdata = m;
      @(posedge clk); #1;
      bus.c0_req_valid = 1'b0;
   endtask

   task automatic wr_req(input logic [41:0] a, input logic [511:0] d, input logic [15:0] m, input logic f);
      model_wr(cyc, a, d, m, f);
      bus.c1_req_valid = 1'b1; bus.c1_req_fence = f; bus.c1_req_addr = a;
      bus.c1_req_data = d; bus.c1_req_mdata = m;
      @(posedge clk); #1;
      bus.c1_req_valid = 1'b0; bus.c1_req_fence = 1'b0;
   endtask

   task automatic test_reset();
      bus.c0_req_valid = 1'b0; bus.c0_req_addr = '0; bus.c0_req_mdata = '0;
      bus.c1_req_valid = 1'b0; bus.c1_req_fence = 1'b0; bus.c1_req_addr = '0;
      bus.c1_req_data = '0; bus.c1_req_mdata = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.c0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_c0_valid: got %b want 0", bus.c0_rsp_valid); end
      n_checks++; if (bus.c1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_c1_valid: got %b want 0", bus.c1_rsp_valid); end
      n_checks++; if (bus.c0_almfull !== 1'b0) begin n_fail++; $display("FAIL reset_c0_almfull: got %b want 0", bus.c0_almfull); end
      n_checks++; if (bus.c1_almfull !== 1'b0) begin n_fail++; $display("FAIL reset_c1_almfull: got %b want 0", bus.c1_almfull); end
      n_checks++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow_err); end
   endtask

   task automatic test_write_read();
      logic [511:0] d = {64{8'hA5}};
      flush();
      wr_req(42'h5, d, 16'h11, 1'b0);
      repeat (4) @(posedge clk); #1;
      rd_req(42'h5, 16'h22);
      repeat (12) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (c1_obs.size() != 1 || c1_obs[0].cyc !== c1_exp[0].cyc || c1_obs[0].mdata !== 16'h11 || c1_obs[0].fence !== 1'b0) begin
         n_fail++; $display("FAIL wr_ack: got %0d acks, first cyc %0d mdata %h; want 1 ack cyc %0d mdata 11 fence 0",
                            c1_obs.size(), c1_obs.size() ? c1_obs[0].cyc : 0, c1_obs.size() ? c1_obs[0].mdata : 16'h0, c1_exp[0].cyc);
      end
      n_checks++;
      if (c0_obs.size() != 1 || c0_obs[0].cyc !== c0_exp[0].cyc || c0_obs[0].mdata !== 16'h22 || c0_obs[0].data !== d) begin
         n_fail++; $display("FAIL rd_rsp: got %0d rsps, first cyc %0d mdata %h; want 1 rsp cyc %0d mdata 22 data A5..",
                            c0_obs.size(), c0_obs.size() ? c0_obs[0].cyc : 0, c0_obs.size() ? c0_obs[0].mdata : 16'h0, c0_exp[0].cyc);
      end
   endtask

   task automatic test_burst();
      int idx [10];
      flush();
      for (int i = 0; i < 10; i++) begin
         idx[i] = $urandom_range(0, 1023);
         wr_req({$urandom(), 10'(idx[i])}, rand_line(), 16'(16'h100 + i), 1'b0);
      end
      repeat (4) @(posedge clk); #1;
      for (int i = 0; i < 10; i++) rd_req({$urandom(), 10'(idx[i])}, 16'(i));
      repeat (12) @(posedge clk);
      @(negedge clk);
      n_checks++; if (c1_obs.size() != 10) begin n_fail++; $display("FAIL burst_wr_count: got %0d want 10", c1_obs.size()); end
      for (int i = 0; i < 10 && i < c1_obs.size(); i++) begin
         n_checks++;
         if (c1_obs[i].cyc !== c1_exp[i].cyc || c1_obs[i].mdata !== c1_exp[i].mdata || c1_obs[i].fence !== 1'b0) begin
            n_fail++; $display("FAIL burst_wr[%0d]: got cyc %0d mdata %h want cyc %0d mdata %h",
                               i, c1_obs[i].cyc, c1_obs[i].mdata, c1_exp[i].cyc, c1_exp[i].mdata);
         end
      end
      n_checks++; if (c0_obs.size() != 10) begin n_fail++; $display("FAIL burst_rd_count: got %0d want 10", c0_obs.size()); end
      for (int i = 0; i < 10 && i < c0_obs.size(); i++) begin
         n_checks++;
         if (c0_obs[i].cyc !== c0_exp[i].cyc || c0_obs[i].mdata !== c0_exp[i].mdata || c0_obs[i].data !== c0_exp[i].data) begin
            n_fail++; $display("FAIL burst_rd[%0d]: got cyc %0d mdata %h data %h want cyc %0d mdata %h data %h",
                               i, c0_obs[i].cyc, c0_obs[i].mdata, c0_obs[i].data, c0_exp[i].cyc, c0_exp[i].mdata, c0_exp[i].data);
         end
      end
   endtask

   task automatic test_almfull();
      flush();
      force dut.rd_hold = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) rd_req({$urandom(), 10'h5}, 16'(i));
         else begin
            bus.c0_req_valid = 1'b1; bus.c0_req_addr = 42'h5; bus.c0_req_mdata = 16'hDEAD;
            @(posedge clk); #1;
            bus.c0_req_valid = 1'b0;
         end
         @(negedge clk);
         if (i == 10) begin
            n_checks++; if (bus.c0_almfull !== 1'b0) begin n_fail++; $display("FAIL almfull_11: got %b want 0", bus.c0_almfull); end
         end
         if (i == 11) begin
            n_checks++; if (bus.c0_almfull !== 1'b1) begin n_fail++; $display("FAIL almfull_12: got %b want 1", bus.c0_almfull); end
         end
         if (i == 15) begin
            n_checks++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL overflow_16: got %b want 0", bus.overflow_err); end
         end
         if (i == 16) begin
            n_checks++; if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL overflow_17: got %b want 1", bus.overflow_err); end
         end
      end
      n_checks++; if (c0_obs.size() != 0) begin n_fail++; $display("FAIL hold_no_rsp: got %0d rsps want 0", c0_obs.size()); end
      release dut.rd_hold;
      repeat (40) @(posedge clk);
      @(negedge clk);
      n_checks++; if (c0_obs.size() != 16) begin n_fail++; $display("FAIL drain_count: got %0d want 16", c0_obs.size()); end
      for (int i = 0; i < 16 && i < c0_obs.size(); i++) begin
         n_checks++;
         if (c0_obs[i].mdata !== c0_exp[i].mdata || c0_obs[i].data !== c0_exp[i].data) begin
            n_fail++; $display("FAIL drain[%0d]: got mdata %h want mdata %h", i, c0_obs[i].mdata, c0_exp[i].mdata);
         end
      end
      n_checks++; if (bus.c0_almfull !== 1'b0) begin n_fail++; $display("FAIL almfull_drained: got %b want 0", bus.c0_almfull); end
      n_checks++; if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b want 1", bus.overflow_err); end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL overflow_cleared: got %b want 0", bus.overflow_err); end
   endtask

   task automatic test_fence();
      logic [41:0] a, b;
      flush();
      a = {$urandom(), 10'($urandom_range(0, 511))};
      b = {$urandom(), 10'($urandom_range(512, 1023))};
      wr_req(a, rand_line(), 16'hA1, 1'b0);
      wr_req(b, rand_line(), 16'hB2, 1'b0);
      wr_req(a, rand_line(), 16'hF0, 1'b1);
      rd_req(a, 16'h0A);
      rd_req(b, 16'h0B);
      repeat (12) @(posedge clk);
      @(negedge clk);
      n_checks++; if (c1_obs.size() != 3) begin n_fail++; $display("FAIL fence_count: got %0d want 3", c1_obs.size()); end
      for (int i = 0; i < 3 && i < c1_obs.size(); i++) begin
         n_checks++;
         if (c1_obs[i].cyc !== c1_exp[i].cyc || c1_obs[i].mdata !== c1_exp[i].mdata || c1_obs[i].fence !== c1_exp[i].fence) begin
            n_fail++; $display("FAIL fence_ack[%0d]: got cyc %0d mdata %h fence %b want cyc %0d mdata %h fence %b",
                               i, c1_obs[i].cyc, c1_obs[i].mdata, c1_obs[i].fence, c1_exp[i].cyc, c1_exp[i].mdata, c1_exp[i].fence);
         end
      end
      n_checks++; if (c0_obs.size() != 2) begin n_fail++; $display("FAIL fence_rd_count: got %0d want 2", c0_obs.size()); end
      for (int i = 0; i < 2 && i < c0_obs.size(); i++) begin
         n_checks++;
         if (c0_obs[i].cyc !== c0_exp[i].cyc || c0_obs[i].mdata !== c0_exp[i].mdata || c0_obs[i].data !== c0_exp[i].data) begin
            n_fail++; $display("FAIL fence_rd[%0d]: got cyc %0d mdata %h data %h want cyc %0d mdata %h data %h",
                               i, c0_obs[i].cyc, c0_obs[i].mdata, c0_obs[i].data, c0_exp[i].cyc, c0_exp[i].mdata, c0_exp[i].data);
         end
      end
   endtask

   task automatic test_collision();
      logic [511:0] x, y;
      flush();
      x = rand_line();
      y = rand_line();
      wr_req(42'h3, x, 16'h31, 1'b0);
      repeat (3) @(posedge clk); #1;
      model_rd(cyc, 42'h3, 16'h33);
      model_wr(cyc, 42'h3, y, 16'h44, 1'b0);
      bus.c0_req_valid = 1'b1; bus.c0_req_addr = 42'h3; bus.c0_req_mdata = 16'h33;
      bus.c1_req_valid = 1'b1; bus.c1_req_fence = 1'b0; bus.c1_req_addr = 42'h3;
      bus.c1_req_data = y; bus.c1_req_mdata = 16'h44;
      @(posedge clk); #1;
      bus.c0_req_valid = 1'b0; bus.c1_req_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      rd_req({32'hFFFF_FFFF, 10'h3}, 16'h55);
      repeat (12) @(posedge clk);
      @(negedge clk);
      n_checks++; if (c1_obs.size() != 2) begin n_fail++; $display("FAIL coll_wr_count: got %0d want 2", c1_obs.size()); end
      n_checks++; if (c0_obs.size() != 2) begin n_fail++; $display("FAIL coll_rd_count: got %0d want 2", c0_obs.size()); end
      for (int i = 0; i < 2 && i < c0_obs.size(); i++) begin
         n_checks++;
         if (c0_obs[i].cyc !== c0_exp[i].cyc || c0_obs[i].mdata !== c0_exp[i].mdata || c0_obs[i].data !== c0_exp[i].data) begin
            n_fail++; $display("FAIL coll_rd[%0d]: got cyc %0d mdata %h data %h want cyc %0d mdata %h data %h",
                               i, c0_obs[i].cyc, c0_obs[i].mdata, c0_obs[i].data, c0_exp[i].cyc, c0_exp[i].mdata, c0_exp[i].data);
         end
      end
   endtask

   task automatic test_reset_midflight();
      flush();
      for (int i = 0; i < 4; i++) rd_req({$urandom(), 10'h5}, 16'(16'h60 + i));
      repeat (3) @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      force dut.rd_hold = 1'b1;
      for (int i = 0; i < 4; i++) rd_req(42'h5, 16'(16'h70 + i));
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      release dut.rd_hold;
      repeat (25) @(posedge clk);
      @(negedge clk);
      n_checks++; if (c0_obs.size() != 0) begin n_fail++; $display("FAIL midflight_rsp: got %0d rsps want 0", c0_obs.size()); end
      n_checks++; if (bus.c0_almfull !== 1'b0) begin n_fail++; $display("FAIL midflight_c0_almfull: got %b want 0", bus.c0_almfull); end
      n_checks++; if (bus.c1_almfull !== 1'b0) begin n_fail++; $display("FAIL midflight_c1_almfull: got %b want 0", bus.c1_almfull); end
      n_checks++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL midflight_overflow: got %b want 0", bus.overflow_err); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_burst();
      test_almfull();
      test_fence();
      test_collision();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
